// File: rtl/serial_demux_rx_pkg.sv
// Shared definitions for the serial demultiplexing receiver and its slot sequencer.
package serial_demux_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_demux_rx_slot_index_counter.sv
// Slot index counter: wraps modulo 2**SEL_W, sync clear, enable, terminal-count flag.
module serial_demux_rx_slot_index_counter #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Slot count is a power of two, so the last slot is the all-ones index.
  assign tc = &count;

endmodule

// File: rtl/serial_demux_rx.sv
// Serial-to-parallel demux receiver; routes each valid bit into slot dout[sel].
// Optional even-parity bit per frame is compiled in with SERIAL_DEMUX_PARITY_EN.
module serial_demux_rx
  import serial_demux_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             par_err
);

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] word_next;
  logic             accept;
  logic             last_slot;

  // A data bit is taken only in RECV; a coincident start wins and restarts the frame.
  assign accept = (state == RECV) && din_valid && !start;

  serial_demux_rx_slot_index_counter #(
    .SEL_W(SEL_W)
  ) u_slot_index_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (accept),
    .count(sel),
    .tc   (last_slot)
  );

  always_comb begin
    word_next      = shadow;
    word_next[sel] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
`ifdef SERIAL_DEMUX_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      dout_valid <= 1'b0;
      if (start) begin
        state  <= RECV;
        busy   <= 1'b1;
        shadow <= '0;
      end else begin
        case (state)
          RECV: begin
            if (din_valid) begin
              shadow <= word_next;
              if (last_slot) begin
`ifdef SERIAL_DEMUX_PARITY_EN
                state <= PAR;
`else
                dout       <= word_next;
                dout_valid <= 1'b1;
                state      <= IDLE;
                busy       <= 1'b0;
`endif
              end
            end
          end
`ifdef SERIAL_DEMUX_PARITY_EN
          PAR: begin
            // The bit after the word makes the total count of ones even.
            if (din_valid) begin
              dout       <= shadow;
              dout_valid <= 1'b1;
              par_err    <= (^shadow) != din;
              state      <= IDLE;
              busy       <= 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifndef SERIAL_DEMUX_PARITY_EN
  assign par_err = 1'b0;
`endif

endmodule
